// File: rtl/noise_mix_dac.sv
// PN-noise + signal mixer: packs PN bits into a signed word, scales by amp, adds the
// antipodal signal level, clips to DW bits and ships each sample as a 16-bit SPI frame.
module noise_mix_dac #(
  parameter int          NW      = 8,
  parameter int          DW      = 10,
  parameter int          SPI_DIV = 4,
  parameter logic [3:0]  CTRL    = 4'hC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          noise_in,
  input  logic          sig_in,
  input  logic [DW-2:0] sig_lvl,
  input  logic [3:0]    amp,
  input  logic          sample_tick,
  output logic [DW-1:0] sample_out,
  output logic          sample_valid,
  output logic          busy,
  output logic          overrun,
  output logic          cs_n,
  output logic          sclk,
  output logic          dout
);
  localparam int SW = DW + NW + 6;
  localparam int CW = $clog2(SPI_DIV);
  localparam logic signed [SW-1:0] MID  = SW'(2**(DW-1));
  localparam logic signed [SW-1:0] MAXV = SW'(2**DW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   nreg_q, nreg_d;
  logic [DW-1:0]   sample_q, sample_d;
  logic            valid_q, valid_d, overrun_q, overrun_d;
  logic            cs_n_q, cs_n_d, sclk_q, sclk_d, dout_q, dout_d;
  logic [15:0]     frame_q, frame_d, frame_new;
  logic [CW-1:0]   div_cnt_q, div_cnt_d;
  logic [4:0]      tog_cnt_q, tog_cnt_d;
  logic signed [SW-1:0] n_s, lvl_s, sum_s;
  logic [DW-1:0]   samp_c;
  logic            div_wrap, last_tog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      nreg_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      dout_q    <= 1'b0;
      frame_q   <= '0;
      div_cnt_q <= '0;
      tog_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      nreg_q    <= nreg_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      dout_q    <= dout_d;
      frame_q   <= frame_d;
      div_cnt_q <= div_cnt_d;
      tog_cnt_q <= tog_cnt_d;
    end
  end

  // Sign-extend the PN history, scale, add the antipodal level around mid-scale, clip.
  always_comb begin
    n_s   = $signed({{(SW-NW){nreg_q[NW-1]}}, nreg_q}) * $signed({{(SW-4){1'b0}}, amp});
    lvl_s = $signed({{(SW-DW+1){1'b0}}, sig_lvl});
    sum_s = MID + (sig_in ? lvl_s : -lvl_s) + n_s;
    if (sum_s < 0)         samp_c = '0;
    else if (sum_s > MAXV) samp_c = '1;
    else                   samp_c = sum_s[DW-1:0];
    frame_new = 16'({CTRL, samp_c}) << (12 - DW);
  end

  assign div_wrap = (div_cnt_q == CW'(SPI_DIV - 1));
  assign last_tog = div_wrap && sclk_q && (tog_cnt_q == 5'd31);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick) state_d = SHIFT;
      SHIFT:   if (last_tog)    state_d = GAP;
      GAP:     if (div_wrap)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nreg_d    = {nreg_q[NW-2:0], noise_in};
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (sample_tick && (state_q != IDLE));
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    dout_d    = dout_q;
    frame_d   = frame_q;
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    tog_cnt_d = tog_cnt_q;
    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        tog_cnt_d = '0;
        cs_n_d    = 1'b1;
        sclk_d    = 1'b0;
        dout_d    = 1'b0;
        if (sample_tick) begin
          sample_d = samp_c;
          valid_d  = 1'b1;
          frame_d  = frame_new;
          dout_d   = frame_new[15];
          cs_n_d   = 1'b0;
        end
      end
      SHIFT: if (div_wrap) begin
        sclk_d    = ~sclk_q;
        tog_cnt_d = tog_cnt_q + 5'd1;
        if (last_tog) begin
          cs_n_d = 1'b1;
          dout_d = 1'b0;
        end else if (sclk_q) begin
          // falling edge: present the next bit so it is stable around the rising edge
          frame_d = frame_q << 1;
          dout_d  = frame_q[14];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    sample_out   = sample_q;
    sample_valid = valid_q;
    overrun      = overrun_q;
    cs_n         = cs_n_q;
    sclk         = sclk_q;
    dout         = dout_q;
  end
endmodule

// File: tb/tb_noise_mix_dac.sv
// Directed bench for noise_mix_dac: expected frames queued at each tick, popped when cs_n rises.
module tb_noise_mix_dac;
  localparam int NW = 8, DW = 10, SPI_DIV = 4;

  logic          clk = 1'b0;
  logic          rst, noise_in, sig_in, sample_tick;
  logic [DW-2:0] sig_lvl;
  logic [3:0]    amp;
  logic [DW-1:0] sample_out;
  logic          sample_valid, busy, overrun, cs_n, sclk, dout;

  int checks = 0, errors = 0;
  logic [15:0] exp_q[$];

  noise_mix_dac #(.NW(NW), .DW(DW), .SPI_DIV(SPI_DIV), .CTRL(4'hC)) dut (
    .clk(clk), .rst(rst), .noise_in(noise_in), .sig_in(sig_in), .sig_lvl(sig_lvl),
    .amp(amp), .sample_tick(sample_tick), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun),
    .cs_n(cs_n), .sclk(sclk), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input logic [7:0] nr, input logic s, input int lvl, input int a);
    int v;
    v = 512 + (s ? lvl : -lvl) + int'($signed(nr)) * a;
    if (v < 0)    v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  // Shift in an 8-bit PN pattern (oldest bit first), then tick with the given mix settings.
  task automatic send(input logic [7:0] pat, input logic s, input int lvl, input int a);
    int v;
    logic [15:0] f;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      noise_in = pat[i];
    end
    @(negedge clk);
    sig_in = s; sig_lvl = lvl[DW-2:0]; amp = a[3:0]; sample_tick = 1'b1;
    v = model(pat, s, lvl, a);
    f = {4'hC, v[9:0], 2'b00};
    exp_q.push_back(f);
    @(posedge clk); #1;
    chk("valid_pulse", 32'(sample_valid), 1);
    chk("sample_out", 32'(sample_out), v);
    chk("busy_on", 32'(busy), 1);
    sample_tick = 1'b0;
    @(posedge clk); #1;
    chk("valid_low", 32'(sample_valid), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_sample_out", 32'(sample_out), 0);
    chk("rst_valid", 32'(sample_valid), 0);
  endtask

  // Frame monitor: captures dout on sclk rising edges and times cs_n / busy windows.
  initial begin
    bit ps = 0, pc = 1, pb = 0;
    int nb = 0, lc = 0, bc = 0;
    logic [15:0] sh = '0, e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ps = 0; pc = 1; pb = 0; nb = 0; lc = 0; bc = 0; sh = '0;
      end else begin
        if (!cs_n) lc++;
        if (busy) bc++;
        if (sclk && !ps) begin
          chk("edge_centre", lc, 5 + 8 * nb);
          sh = {sh[14:0], dout};
          nb++;
        end
        if (cs_n && !pc) begin
          chk("cs_low_cycles", lc, 128);
          chk("sclk_edges", nb, 16);
          chk("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame", 32'(sh), 32'(e));
          end
          lc = 0; nb = 0; sh = '0;
        end
        if (!busy && pb) begin
          chk("busy_cycles", bc, 132);
          bc = 0;
        end
        ps = sclk; pc = cs_n; pb = busy;
      end
    end
  end

  initial begin
    rst = 1'b1; noise_in = 1'b0; sig_in = 1'b0; sig_lvl = '0; amp = '0; sample_tick = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    send(8'h00, 1'b1, 100, 3);  wait_idle();   // 612, frame C990
    send(8'hFF, 1'b0, 511, 15); wait_idle();   // -14 -> 0, frame C000
    send(8'h7F, 1'b1, 511, 15); wait_idle();   // 2928 -> 1023, frame CFFC
    send(8'hA5, 1'b1, 200, 2);  wait_idle();
    send(8'h80, 1'b0, 0, 0);    wait_idle();   // amp=0: pure signal

    chk("overrun_clear", 32'(overrun), 0);
    send(8'h3C, 1'b0, 50, 1);
    repeat (40) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    #1;
    chk("overrun_set", 32'(overrun), 1);
    wait_idle();
    send(8'h12, 1'b1, 0, 7);
    chk("overrun_sticky", 32'(overrun), 1);
    wait_idle();

    // abort a frame during bit 7, then send a clean one
    send(8'h55, 1'b1, 300, 4);
    repeat (56) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(8'h55, 1'b1, 300, 4);
    wait_idle();
    chk("overrun_after_rst", 32'(overrun), 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/noise_mix_dac.md
Name: noise_mix_dac

Overview:
- Downstream consumer of the 1-bit PN noise generator's output.
- Packs the PN bitstream into signed noise words and scales them by a programmable amplitude.
- Adds the scaled noise to the antipodal level of the digital test-signal bit, clips the sum to the DAC range and sends each sample to a 16-bit serial DAC over an SPI-style write frame.
- One sample is taken per sample_tick from the rate generator.

Parameters:
NW, 8, noise word width (bits of PN history used per sample)
DW, 10, DAC sample width (DW <= 12)
SPI_DIV, 4, clk cycles per sclk half-period (>= 2)
CTRL, 4'hC, DAC control nibble prepended to every frame

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
noise_in  input  1  PN bit from the noise generator, one new bit per clk
sig_in  input  1  digital signal bit (1 -> +level, 0 -> -level)
sig_lvl  input  DW-1  signal amplitude, unsigned
amp  input  4  noise gain 0..15
sample_tick  input  1  one-cycle request to produce and send a sample
sample_out  output  DW  last computed (clipped) sample, offset binary
sample_valid  output  1  one-cycle pulse when sample_out updates
busy  output  1  high while a frame or the inter-frame gap is in progress
overrun  output  1  sticky; a tick arrived while busy
cs_n  output  1  DAC chip select, active low
sclk  output  1  DAC serial clock
dout  output  1  DAC serial data, MSB first

Behaviour:
- Reset (async, any state): nreg=0, state=IDLE, sample_out=0, sample_valid=0, busy=0, overrun=0, cs_n=1, sclk=0, dout=0, all counters 0.
- Noise collector: every clk, nreg <= {nreg[NW-2:0], noise_in}. The collector runs in every state.
- Sample arithmetic, in a signed width of at least DW+NW+6:
  - n = signed(nreg) * amp.
  - s = 2^(DW-1) + (sig_in ? +sig_lvl : -sig_lvl) + n.
  - Clip: s<0 -> 0; s>2^DW-1 -> 2^DW-1.
  - amp=0 yields the pure signal.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - Outputs cs_n=1, sclk=0, busy=0.
  - On sample_tick, the sample is computed from the current nreg and the input values. On the next edge: sample_out is loaded, sample_valid is pulsed for 1 cycle, frame <= {CTRL, sample, (12-DW) zeros}, dout=frame[15], cs_n=0, busy=1, div_cnt=0, state -> SHIFT.
- SHIFT:
  - div_cnt counts 0..SPI_DIV-1; at SPI_DIV-1 it wraps to 0 and sclk toggles.
  - The DAC samples dout on sclk rising edges.
  - On each falling toggle, frame shifts left and dout takes the next bit.
  - After the 32nd toggle (16th falling edge): cs_n=1, dout=0, state -> GAP.
  - cs_n is low for exactly 32*SPI_DIV cycles.
- GAP:
  - cs_n=1, sclk=0, busy=1 for SPI_DIV cycles, then state -> IDLE.
- Tick acceptance:
  - A tick is accepted only when the state register is IDLE. A tick in the same cycle that GAP exits is not accepted.
  - A tick in SHIFT or GAP sets overrun=1, is discarded and leaves the frame untouched.
  - overrun is cleared only by rst.
- Reset mid-frame: the frame aborts immediately with cs_n=1 and sclk=0. There is no resumption; the next accepted tick sends a complete frame.

Test Plan (NW=8, DW=10, SPI_DIV=4, CTRL=4'hC):
1. Reset: assert rst mid-run -> cs_n=1, sclk=0, dout=0, busy=0, overrun=0 and sample_out=0 in the same cycle, without waiting for clk.
2. Signal only:
   - Stimulus: noise_in=0 for >=8 cycles, sig_in=1, sig_lvl=100, amp=3, tick.
   - Response: sample_out=612, sample_valid pulse of 1 cycle; the frame captured on sclk rising edges is 16'hC990.
3. Lower clip:
   - Stimulus: noise_in=1 for >=8 cycles (nreg=-1), amp=15, sig_in=0, sig_lvl=511, tick.
   - Response: raw value -14 -> sample_out=0, frame 16'hC000.
4. Upper clip:
   - Stimulus: noise_in pattern giving nreg=8'h7F (127), amp=15, sig_in=1, sig_lvl=511, tick.
   - Response: raw value 2928 -> sample_out=1023, frame 16'hCFFC.
5. Frame timing and overrun:
   - Stimulus: one tick, then a second tick issued mid-SHIFT.
   - Response: cs_n low exactly 128 cycles; exactly 16 sclk rising edges; each edge at the centre of a stable dout bit; busy high 132 cycles.
   - Second tick: overrun=1, no second frame; a later tick in IDLE sends a new frame and overrun stays 1.
6. Reset mid-frame:
   - Stimulus: rst during bit 7, released, then a tick.
   - Response: on rst, cs_n=1 immediately; after release, a full 16-bit frame with correct data.
